clint: RTL
==========

CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16'd100: core clocks per mtime increment (16-bit, valid range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  bus request valid.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_wen  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  16  byte offset; only 8-byte-aligned accesses defined.
REQ-008 SHALL have port req_wdata  input  64  write data.
REQ-009 SHALL have port resp_rdata  output  64  read data; 0 for writes.
REQ-010 SHALL have port resp_err  output  1  unmapped or misaligned address.
REQ-011 SHALL have port resp_valid  output  1  response valid.
REQ-012 SHALL have port resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-013 SHALL have port extint_software  output  1  level, equal to registered msip[0].
REQ-014 SHALL have port extint_timer  output  1  level, registered (mtime >= mtimecmp).

Function
REQ-015 SHALL implement a register map: MSIP 0x0000 (bit0 read/write, bits 63:1 read 0, writes ignored), MTIMECMP 0x4000 (64-bit read/write), MTIME 0xBFF8 (64-bit read/write).
REQ-016 SHALL run a two-state FSM: IDLE (req_ready=1, resp_valid=0) and RESP (req_ready=0, resp_valid=1); one outstanding request maximum.
REQ-017 SHALL go IDLE->RESP on an accepted request, registering resp_rdata/resp_err in that same edge, so the response is valid the cycle after acceptance.
REQ-018 SHALL hold resp_rdata/resp_err stable in RESP until resp_ready; RESP->IDLE on resp_ready; no new request accepted in the same cycle.
REQ-019 SHALL commit a write to its register on the acceptance edge; the read of MTIME returns the value before any increment on that edge.
REQ-020 SHALL, for an unmapped or misaligned req_addr (req_addr[2:0]!=0), ignore the write, return rdata 0 and resp_err=1.
REQ-021 SHALL keep a 16-bit prescaler counting 0..TICK_DIV-1; on the cycle it equals TICK_DIV-1 it wraps to 0 and mtime increments by 1.
REQ-022 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no side effect.
REQ-023 SHALL give a software write to MTIME priority over a same-cycle tick; the prescaler is not reset by the write.
REQ-024 SHALL compute extint_timer with an unsigned 64-bit compare of the current registered mtime and mtimecmp, registered: output changes one cycle after either operand changes.
REQ-025 SHALL deassert extint_timer only via mtimecmp increase or mtime write/wrap; no level-clear side effects on read.
REQ-026 SHALL update extint_software one cycle after an MSIP write commits.

Reset
REQ-027 SHALL, on rst assertion (asynchronous, any state, including mid-transaction in RESP), set: state IDLE, msip 0, mtimecmp all-ones, mtime 0, prescaler 0, resp_valid 0, resp_rdata 0, resp_err 0, extint_software 0, extint_timer 0; a pending response is discarded.
REQ-028 SHALL keep req_ready at 1 while rst is asserted.

Configuration
REQ-029 SHALL support macro CLINT_PRESCALER_EN: when defined, the prescaler of REQ-021 is used; when undefined, there is no prescaler logic, mtime increments every cycle and TICK_DIV is ignored.

Verification
REQ-030 SHALL cover: reset, then read 0xBFF8 with TICK_DIV=4 at cycle 40 after reset release -> resp_rdata=10 (prescaler build), 40 (no prescaler), resp_err=0.
REQ-031 SHALL cover: write MTIMECMP=5, TICK_DIV=1 -> extint_timer rises exactly one cycle after mtime reaches 5; write MTIMECMP=all-ones -> extint_timer falls one cycle later.
REQ-032 SHALL cover: write MSIP=64'h3 -> extint_software=1 next cycle, read MSIP returns 1; write 0 -> extint_software=0.
REQ-033 SHALL cover: read 0x1234 and 0x4004 -> resp_err=1, rdata=0, no register changed.
REQ-034 SHALL cover: hold resp_ready=0 for 10 cycles with req_valid high -> resp_valid and resp_rdata stable, req_ready=0; one response only.
REQ-035 SHALL cover: write MTIME=64'hFFFF_FFFF_FFFF_FFFE on a tick cycle, TICK_DIV=1 -> mtime reads ...FFFF then 0, and the write value wins over the tick; assert rst while in RESP -> resp_valid=0 immediately.

Source files
------------

// File: rtl/clint.sv
// clint: core-local interruptor with MSIP, MTIMECMP and MTIME on a valid/ready bus.
// Ports: clk/rst (async, active-high); req_valid/req_ready/req_wen/req_addr/req_wdata request channel;
//        resp_valid/resp_ready/resp_rdata/resp_err response channel; extint_software, extint_timer levels.
// Build option: define CLINT_PRESCALER_EN to advance mtime once every TICK_DIV clocks; otherwise every clock.
module clint #(
  parameter logic [15:0] TICK_DIV = 16'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        extint_software,
  output logic        extint_timer
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic msip;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;
  logic tick;
  logic accept;
  logic hit_msip;
  logic hit_cmp;
  logic hit_time;
  logic [63:0] rd;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept     = req_ready && req_valid;
  // Exact-offset matches also reject every misaligned address.
  assign hit_msip = req_addr == 16'h0000;
  assign hit_cmp  = req_addr == 16'h4000;
  assign hit_time = req_addr == 16'hBFF8;
  assign rd = hit_msip ? {63'd0, msip} : hit_cmp ? mtimecmp : hit_time ? mtime : 64'd0;
`ifdef CLINT_PRESCALER_EN
  logic [15:0] presc;
  assign tick = presc == TICK_DIV - 16'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) presc <= 16'd0;
    else presc <= tick ? 16'd0 : presc + 16'd1;
`else
  // Every clock is a tick; a zero divider is outside the legal range and never occurs.
  assign tick = TICK_DIV != 16'd0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      msip            <= 1'b0;
      mtimecmp        <= '1;
      mtime           <= 64'd0;
      resp_rdata      <= 64'd0;
      resp_err        <= 1'b0;
      extint_software <= 1'b0;
      extint_timer    <= 1'b0;
    end else begin
      extint_software <= msip;
      extint_timer    <= mtime >= mtimecmp;
      // A software write to mtime overrides the tick increment on the same edge.
      mtime <= (accept && req_wen && hit_time) ? req_wdata : mtime + 64'(tick);
      if (accept && req_wen && hit_msip) msip <= req_wdata[0];
      if (accept && req_wen && hit_cmp) mtimecmp <= req_wdata;
      if (accept) begin
        state      <= RESP;
        resp_rdata <= req_wen ? 64'd0 : rd;
        resp_err   <= !(hit_msip || hit_cmp || hit_time);
      end else if (state == RESP && resp_ready) state <= IDLE;
    end
endmodule
